// File: rtl/stack_cpu_ctrl_if.sv
// Bus bundle for stack_cpu_ctrl: run control, shared memory port,
// datapath strobes and status.
//   master : the controller (drives address/strobes/status)
//   slave  : the surrounding system (drives en, mem_load, mem_rdata)
interface stack_cpu_ctrl_if #(
  parameter int SP_W = 4
);
  logic            en;
  logic            mem_load;
  logic [7:0]      mem_rdata;
  logic [7:0]      mem_addr;
  logic            mem_we;
  logic            mem_sel;
  logic [7:0]      operand;
  logic            stk_push;
  logic [1:0]      stk_src;
  logic            stk_pop;
  logic            alu_exec;
  logic            alu_sub;
  logic [SP_W-1:0] sp;
  logic [7:0]      pc;
  logic            halted;
  logic            fault;
  logic [1:0]      fault_code;

  modport master (
    input  en, mem_load, mem_rdata,
    output mem_addr, mem_we, mem_sel, operand, stk_push, stk_src, stk_pop,
           alu_exec, alu_sub, sp, pc, halted, fault, fault_code
  );

  modport slave (
    output en, mem_load, mem_rdata,
    input  mem_addr, mem_we, mem_sel, operand, stk_push, stk_src, stk_pop,
           alu_exec, alu_sub, sp, pc, halted, fault, fault_code
  );
endinterface

// File: rtl/stack_cpu_ctrl.sv
// Stack CPU controller: fetches 1/2-byte instructions over a shared
// synchronous-read memory port, tracks stack depth and drives one-cycle
// strobes to an external stack/ALU datapath.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - stack_cpu_ctrl_if.master (en, mem_load, mem_rdata in;
//           memory address/write, datapath strobes, pc/sp/status out)
module stack_cpu_ctrl #(
  parameter int DEPTH = 8,
  parameter int SP_W  = 4
) (
  input logic              clk,
  input logic              rst_n,
  stack_cpu_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, OPFETCH, OPLATCH, MREAD, EXEC, HALTED, FAULT
  } state_t;

  typedef enum logic [3:0] {
    OP_PUSHC = 4'h0, OP_PUSHM = 4'h1, OP_POP = 4'h2,
    OP_HALT  = 4'h3, OP_ADD   = 4'h6, OP_SUB = 4'h7
  } opcode_t;

  state_t          state;
  logic [7:0]      pc_q;
  logic [SP_W-1:0] sp_q;
  logic [3:0]      ir_op;        // IR[3:0] is don't-care, so only the opcode is kept
  logic [7:0]      operand_q;
  logic [7:0]      addr_q;
  logic            halted_q;
  logic            fault_q;
  logic [1:0]      fcode_q;
  logic            push_q, pop_q, alu_q, sub_q;
  logic [1:0]      src_q;

  logic [3:0]      x_op;
  logic            x_ok;
  logic            to_exec;
  logic            run;

  function automatic logic two_byte(input logic [3:0] op);
    return op == OP_PUSHC || op == OP_PUSHM || op == OP_POP;
  endfunction

  function automatic logic legal(input logic [3:0] op);
    return two_byte(op) || op == OP_HALT || op == OP_ADD || op == OP_SUB;
  endfunction

  function automatic logic guard_ok(input logic [3:0] op, input logic [SP_W-1:0] d);
    case (op)
      OP_PUSHC, OP_PUSHM: return d != SP_W'(DEPTH);
      OP_POP:             return d != '0;
      OP_ADD, OP_SUB:     return d >= SP_W'(2);
      default:            return 1'b1;
    endcase
  endfunction

  // Strobes are armed on the edge that enters EXEC so they are registered
  // during EXEC. In DECODE the opcode is still on mem_rdata, not yet in IR.
  // sp cannot change between arming and EXEC, so the guard result agrees.
  always_comb begin
    x_op    = (state == DECODE) ? bus.mem_rdata[7:4] : ir_op;
    x_ok    = guard_ok(x_op, sp_q);
    to_exec = (state == DECODE && legal(x_op) && !two_byte(x_op)) ||
              (state == OPLATCH && ir_op != OP_PUSHM) ||
              (state == MREAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= '0;
      sp_q      <= '0;
      ir_op     <= '0;
      operand_q <= '0;
      addr_q    <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      fcode_q   <= '0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      alu_q     <= 1'b0;
      sub_q     <= 1'b0;
      src_q     <= '0;
    end else if (bus.mem_load) begin
      state    <= IDLE;
      pc_q     <= '0;
      sp_q     <= '0;
      addr_q   <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      fcode_q  <= '0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      alu_q    <= 1'b0;
    end else if (bus.en) begin
      if (to_exec) begin
        push_q <= x_ok && (x_op == OP_PUSHC || x_op == OP_PUSHM);
        src_q  <= (x_op == OP_PUSHM) ? 2'b01 : 2'b00;
        pop_q  <= x_ok && (x_op == OP_POP);
        alu_q  <= x_ok && (x_op == OP_ADD || x_op == OP_SUB);
        sub_q  <= (x_op == OP_SUB);
      end else begin
        push_q <= 1'b0;
        pop_q  <= 1'b0;
        alu_q  <= 1'b0;
      end

      case (state)
        IDLE: begin
          state  <= FETCH;
          addr_q <= pc_q;
        end
        FETCH: begin
          pc_q  <= pc_q + 8'd1;
          state <= DECODE;
        end
        DECODE: begin
          ir_op <= x_op;
          if (!legal(x_op)) begin
            state   <= FAULT;
            fault_q <= 1'b1;
            fcode_q <= 2'b11;
          end else if (two_byte(x_op)) begin
            state  <= OPFETCH;
            addr_q <= pc_q;
          end else begin
            state <= EXEC;
          end
        end
        OPFETCH: begin
          pc_q  <= pc_q + 8'd1;
          state <= OPLATCH;
        end
        OPLATCH: begin
          // Operand doubles as the MREAD address (PUSHM) or write address (POP).
          operand_q <= bus.mem_rdata;
          addr_q    <= bus.mem_rdata;
          state     <= (ir_op == OP_PUSHM) ? MREAD : EXEC;
        end
        MREAD: state <= EXEC;
        EXEC: begin
          if (!guard_ok(ir_op, sp_q)) begin
            state   <= FAULT;
            fault_q <= 1'b1;
            fcode_q <= (ir_op == OP_PUSHC || ir_op == OP_PUSHM) ? 2'b01 : 2'b10;
          end else begin
            state  <= FETCH;
            addr_q <= pc_q;
            case (ir_op)
              OP_PUSHC, OP_PUSHM:     sp_q <= sp_q + SP_W'(1);
              OP_POP, OP_ADD, OP_SUB: sp_q <= sp_q - SP_W'(1);
              default: begin
                state    <= HALTED;
                halted_q <= 1'b1;
              end
            endcase
          end
        end
        HALTED, FAULT: state <= state;
        default:       state <= IDLE;
      endcase
    end
  end

  // Gating with en/mem_load keeps a held EXEC silent while frozen and
  // suppresses the strobe of an instruction that mem_load is aborting.
  assign run            = bus.en & ~bus.mem_load;
  assign bus.stk_push   = push_q & run;
  assign bus.stk_pop    = pop_q & run;
  assign bus.mem_we     = pop_q & run;
  assign bus.alu_exec   = alu_q & run;
  assign bus.stk_src    = src_q;
  assign bus.alu_sub    = sub_q;
  assign bus.mem_sel    = ~bus.mem_load;
  assign bus.mem_addr   = addr_q;
  assign bus.operand    = operand_q;
  assign bus.sp         = sp_q;
  assign bus.pc         = pc_q;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fcode_q;

endmodule

// File: tb/tb_stack_cpu_ctrl.sv
// Bench for stack_cpu_ctrl: memory + stack datapath model, directed programs,
// and a scoreboard of expected strobe events checked by a monitor process.
module tb_stack_cpu_ctrl;

  localparam logic [2:0] K_PUSHC = 3'd0, K_PUSHM = 3'd1, K_POP = 3'd2,
                         K_ADD = 3'd3, K_SUB = 3'd4, K_BAD = 3'd7;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] val;
    logic [3:0] sp;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       ld_we = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [7:0] mem [256];
  logic [7:0] stk [$];
  ev_t        exp_q [$];
  int         total = 0;
  int         bad = 0;

  logic [7:0] p1 [18] = '{8'h05, 8'd23, 8'h00, 8'd8, 8'h6A, 8'h20, 8'd21,
                          8'h10, 8'd21, 8'h10, 8'd21, 8'h60, 8'h00, 8'd12,
                          8'h70, 8'h00, 8'd15, 8'h3F};

  stack_cpu_ctrl_if #(.SP_W(4)) bus ();

  stack_cpu_ctrl #(.DEPTH(8), .SP_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tos();
    return (stk.size() != 0) ? stk[$] : 8'h00;
  endfunction

  // Synchronous-read memory with loader port, plus the stack datapath.
  always @(posedge clk) begin
    logic [7:0] a, b;
    if (bus.mem_load) begin
      if (ld_we) mem[ld_addr] <= ld_data;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= tos();
    end
    bus.mem_rdata <= mem[bus.mem_addr];
    if (!rst_n || bus.mem_load) begin
      stk.delete();
    end else if (bus.en) begin
      if (bus.stk_push) stk.push_back(bus.stk_src == 2'b01 ? bus.mem_rdata : bus.operand);
      if (bus.stk_pop && stk.size() != 0) void'(stk.pop_back());
      if (bus.alu_exec && stk.size() >= 2) begin
        b = stk.pop_back();
        a = stk.pop_back();
        stk.push_back(bus.alu_sub ? a - b : a + b);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [7:0] v, input logic [3:0] s);
    exp_q.push_back('{kind: k, val: v, sp: s});
  endtask

  task automatic ld(input int a, input int d);
    ld_addr = 8'(a);
    ld_data = 8'(d);
    ld_we   = 1'b1;
    step(1);
  endtask

  task automatic do_reset();
    bus.en       = 1'b0;
    bus.mem_load = 1'b0;
    ld_we        = 1'b0;
    rst_n        = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic monitor();
    ev_t act, e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.stk_push || bus.stk_pop || bus.alu_exec || bus.mem_we)) begin
        act = '{kind: K_BAD, val: 8'h00, sp: bus.sp};
        if (!bus.en) begin
          act.kind = K_BAD;
        end else if (bus.stk_push && !bus.stk_pop && !bus.alu_exec && !bus.mem_we) begin
          if (bus.stk_src == 2'b00) begin
            act.kind = K_PUSHC;
            act.val  = bus.operand;
          end else if (bus.stk_src == 2'b01) begin
            act.kind = K_PUSHM;
            act.val  = bus.mem_rdata;
          end
        end else if (bus.stk_pop && bus.mem_we && !bus.stk_push && !bus.alu_exec) begin
          act.kind = K_POP;
          act.val  = bus.mem_addr;
        end else if (bus.alu_exec && !bus.stk_push && !bus.stk_pop && !bus.mem_we) begin
          act.kind = bus.alu_sub ? K_SUB : K_ADD;
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL strobe: got kind=%0d val=%0d sp=%0d, required no strobe",
                   act.kind, act.val, act.sp);
        end else begin
          e = exp_q.pop_front();
          if (act != e) begin
            bad++;
            $display("FAIL strobe: got kind=%0d val=%0d sp=%0d, required kind=%0d val=%0d sp=%0d",
                     act.kind, act.val, act.sp, e.kind, e.val, e.sp);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state and full reference program.
    do_reset();
    chk("rst_pc", bus.pc, 0);
    chk("rst_sp", bus.sp, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_fault_code", bus.fault_code, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_operand", bus.operand, 0);
    chk("rst_mem_sel", bus.mem_sel, 1);
    bus.mem_load = 1'b1;
    for (int i = 0; i < 18; i++) ld(i, p1[i]);
    chk("load_mem_sel", bus.mem_sel, 0);
    ld_we = 1'b0;
    bus.mem_load = 1'b0;
    expect_ev(K_PUSHC, 8'd23, 4'd0);
    expect_ev(K_PUSHC, 8'd8,  4'd1);
    expect_ev(K_ADD,   8'd0,  4'd2);
    expect_ev(K_POP,   8'd21, 4'd1);
    expect_ev(K_PUSHM, 8'd31, 4'd0);
    expect_ev(K_PUSHM, 8'd31, 4'd1);
    expect_ev(K_ADD,   8'd0,  4'd2);
    expect_ev(K_PUSHC, 8'd12, 4'd1);
    expect_ev(K_SUB,   8'd0,  4'd2);
    expect_ev(K_PUSHC, 8'd15, 4'd1);
    bus.en = 1'b1;
    step(1);
    step(48);
    chk("prog_halted_c48", bus.halted, 0);
    step(1);
    chk("prog_halted_c49", bus.halted, 1);
    chk("prog_pc", bus.pc, 18);
    chk("prog_sp", bus.sp, 2);
    chk("prog_fault", bus.fault, 0);
    chk("prog_mem21", mem[21], 31);
    chk("prog_events_left", exp_q.size(), 0);
    chk("prog_stack_size", stk.size(), 2);
    if (stk.size() == 2) begin
      chk("prog_nos", stk[0], 50);
      chk("prog_tos", stk[1], 15);
    end
    step(3);
    chk("halt_hold", bus.halted, 1);
    chk("halt_hold_pc", bus.pc, 18);

    // Overflow: nine PUSHC with DEPTH=8.
    do_reset();
    bus.mem_load = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ld(2 * i, 8'h00);
      ld(2 * i + 1, 8'h10 + i);
    end
    ld_we = 1'b0;
    bus.mem_load = 1'b0;
    for (int i = 0; i < 8; i++) expect_ev(K_PUSHC, 8'(8'h10 + i), 4'(i));
    bus.en = 1'b1;
    step(1);
    step(44);
    chk("ovf_fault_early", bus.fault, 0);
    step(1);
    chk("ovf_fault", bus.fault, 1);
    chk("ovf_code", bus.fault_code, 1);
    chk("ovf_sp", bus.sp, 8);
    chk("ovf_pc", bus.pc, 18);
    chk("ovf_events_left", exp_q.size(), 0);

    // Underflow: ADD with empty stack.
    do_reset();
    bus.mem_load = 1'b1;
    ld(0, 8'h60);
    ld_we = 1'b0;
    bus.mem_load = 1'b0;
    bus.en = 1'b1;
    step(1);
    step(2);
    chk("unf_fault_early", bus.fault, 0);
    step(1);
    chk("unf_fault", bus.fault, 1);
    chk("unf_code", bus.fault_code, 2);
    chk("unf_sp", bus.sp, 0);

    // Illegal opcode, fault hold, and clear by mem_load.
    do_reset();
    bus.mem_load = 1'b1;
    ld(0, 8'h50);
    ld_we = 1'b0;
    bus.mem_load = 1'b0;
    bus.en = 1'b1;
    step(1);
    step(1);
    chk("ill_fault_early", bus.fault, 0);
    step(1);
    chk("ill_fault", bus.fault, 1);
    chk("ill_code", bus.fault_code, 3);
    chk("ill_pc", bus.pc, 1);
    step(3);
    chk("ill_hold", bus.fault, 1);
    bus.mem_load = 1'b1;
    step(1);
    chk("ill_clr_fault", bus.fault, 0);
    chk("ill_clr_code", bus.fault_code, 0);
    chk("ill_clr_pc", bus.pc, 0);
    bus.mem_load = 1'b0;
    bus.en = 1'b0;

    // en low for four cycles while PUSHM sits in MREAD.
    do_reset();
    bus.mem_load = 1'b1;
    ld(0, 8'h10);
    ld(1, 8'h40);
    ld(2, 8'h3F);
    ld(8'h40, 8'h5A);
    ld_we = 1'b0;
    bus.mem_load = 1'b0;
    expect_ev(K_PUSHM, 8'h5A, 4'd0);
    bus.en = 1'b1;
    step(1);
    step(4);
    bus.en = 1'b0;
    step(4);
    chk("frz_pc", bus.pc, 2);
    chk("frz_sp", bus.sp, 0);
    chk("frz_addr", bus.mem_addr, 8'h40);
    chk("frz_operand", bus.operand, 8'h40);
    chk("frz_events_pending", exp_q.size(), 1);
    bus.en = 1'b1;
    step(2);
    chk("frz_sp_after", bus.sp, 1);
    chk("frz_events_left", exp_q.size(), 0);
    step(3);
    chk("frz_halted", bus.halted, 1);
    chk("frz_halt_pc", bus.pc, 3);
    // Reset mid-instruction while en stays high.
    bus.mem_load = 1'b1;
    step(1);
    bus.mem_load = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    bus.en = 1'b0;
    rst_n = 1'b1;
    chk("mid_rst_pc", bus.pc, 0);
    chk("mid_rst_operand", bus.operand, 0);
    chk("mid_rst_addr", bus.mem_addr, 0);

    // mem_load raised during EXEC of POP aborts without a write.
    do_reset();
    bus.mem_load = 1'b1;
    ld(0, 8'h00);
    ld(1, 8'h77);
    ld(2, 8'h20);
    ld(3, 8'h30);
    ld(8'h30, 8'hEE);
    ld_we = 1'b0;
    bus.mem_load = 1'b0;
    expect_ev(K_PUSHC, 8'h77, 4'd0);
    bus.en = 1'b1;
    step(1);
    step(5);
    chk("abt_sp_before", bus.sp, 1);
    step(4);
    bus.mem_load = 1'b1;
    step(1);
    chk("abt_pc", bus.pc, 0);
    chk("abt_sp", bus.sp, 0);
    chk("abt_mem_sel", bus.mem_sel, 0);
    chk("abt_fault", bus.fault, 0);
    bus.mem_load = 1'b0;
    bus.en = 1'b0;
    step(1);
    chk("abt_mem30", mem[8'h30], 8'hEE);
    chk("abt_mem_sel_back", bus.mem_sel, 1);
    chk("abt_events_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_cpu_ctrl.md
STACK_CPU_CTRL -- requirements
Module: stack_cpu_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning maximum stack entries.
REQ-002 SHALL have parameter SP_W, default 4, meaning the stack-pointer width; it SHALL hold values 0..DEPTH.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 en  in  1  run enable; 0 freezes all state and forces every strobe to 0.
REQ-006 mem_load  in  1  1 = external loader owns the shared memory port.
REQ-007 mem_rdata  in  8  memory read data, valid one cycle after mem_addr is presented (synchronous read).
REQ-008 mem_addr  out  8  memory address when mem_sel=1.
REQ-009 mem_we  out  1  one-cycle write strobe: write top-of-stack to mem_addr.
REQ-010 mem_sel  out  1  1 = controller owns the memory port; 0 = loader owns it.
REQ-011 operand  out  8  latched second instruction byte.
REQ-012 stk_push  out  1  one-cycle push strobe.
REQ-013 stk_src  out  2  push source: 00 = operand, 01 = mem_rdata; valid with stk_push.
REQ-014 stk_pop  out  1  one-cycle pop strobe.
REQ-015 alu_exec  out  1  one-cycle strobe: datapath pops two entries and pushes the ALU result.
REQ-016 alu_sub  out  1  valid with alu_exec: 0 = ADD (NOS+TOS), 1 = SUB (NOS-TOS), modulo 256.
REQ-017 sp  out  SP_W  current stack depth.
REQ-018 pc  out  8  program counter.
REQ-019 halted  out  1  level, HALT executed.
REQ-020 fault  out  1  level, execution fault.
REQ-021 fault_code  out  2  fault cause: 01 = overflow, 10 = underflow, 11 = illegal opcode.

Function
REQ-022 SHALL decode opcode = IR[7:4] as: 0000 PUSHC, 0001 PUSHM, 0010 POP, 0011 HALT, 0110 ADD, 0111 SUB; PUSHC, PUSHM and POP SHALL carry a second (operand) byte; IR[3:0] SHALL be ignored.
REQ-023 SHALL implement the states IDLE, FETCH, DECODE, OPFETCH, OPLATCH, MREAD, EXEC, HALTED and FAULT.
REQ-024 IDLE SHALL go to FETCH when en=1 and mem_load=0.
REQ-025 FETCH SHALL present mem_addr=pc, increment pc, and go to DECODE.
REQ-026 DECODE SHALL latch IR<=mem_rdata, then go to OPFETCH for a 2-byte opcode, to EXEC for a legal 1-byte opcode, or to FAULT (code 11) for an illegal opcode.
REQ-027 OPFETCH SHALL present mem_addr=pc, increment pc, and go to OPLATCH.
REQ-028 OPLATCH SHALL latch operand<=mem_rdata, then go to MREAD for PUSHM and to EXEC otherwise.
REQ-029 MREAD SHALL present mem_addr=operand and go to EXEC.
REQ-030 EXEC SHALL act per opcode, then go to FETCH:
- PUSHC: stk_push, stk_src=00, sp+1.
- PUSHM: stk_push, stk_src=01, sp+1.
- POP: mem_we=1, mem_addr=operand, stk_pop, sp-1.
- ADD/SUB: alu_exec, alu_sub per opcode, sp-1.
- HALT: no strobe; go to HALTED.
REQ-031 Cycle counts per instruction SHALL be: PUSHC 5, POP 5, PUSHM 6, ADD/SUB 3, HALT 3.
REQ-032 Stack guard, checked in EXEC:
- PUSHC/PUSHM with sp==DEPTH: go to FAULT, code 01.
- POP with sp==0: go to FAULT, code 10.
- ADD/SUB with sp<2: go to FAULT, code 10.
- A faulting EXEC SHALL issue no strobe and leave sp unchanged.
REQ-033 pc SHALL wrap from 255 to 0 without fault.
REQ-034 HALTED and FAULT SHALL hold until reset or mem_load=1, with halted and fault held respectively.
REQ-035 en=0 in any state SHALL hold state, pc, sp, IR and operand, and force mem_we, stk_push, stk_pop and alu_exec to 0.
REQ-036 mem_load=1 in any state SHALL, on the next edge:
- go to IDLE;
- clear pc, sp, halted, fault and fault_code;
- abort any in-flight instruction without strobes.
mem_sel SHALL be 0 while mem_load=1 and 1 otherwise.
REQ-037 mem_load SHALL take priority over en.

Reset
REQ-038 rst_n=0 at a rising edge SHALL set:
- state=IDLE;
- pc=0, sp=0, IR=0, operand=0;
- halted=0, fault=0, fault_code=00;
- all strobes 0, mem_addr=0.
It SHALL take priority over mem_load and en, including in the middle of an instruction.

Verification
REQ-039 Program PUSHC 23, PUSHC 8, ADD, POP 21, PUSHM 21, PUSHM 21, ADD, PUSHC 12, SUB, PUSHC 15, HALT loaded at address 0, then en=1 -> halted=1 after exactly 49 enabled cycles; pc=18; sp=2; the sp trace after each EXEC is 1,2,1,0,1,2,1,2,1,2.
REQ-040 DEPTH=8, nine consecutive PUSHC -> eight stk_push pulses, then fault=1, fault_code=01, sp=8.
REQ-041 Program ADD at address 0 with sp=0 -> fault=1, fault_code=10 at cycle 3, no alu_exec pulse.
REQ-042 Opcode byte 0x50 -> fault=1, fault_code=11 at cycle 2, pc=1.
REQ-043 en toggled low for 4 cycles during PUSHM MREAD -> state, pc and sp frozen; PUSHM completes 4 cycles late with stk_src=01.
REQ-044 mem_load=1 pulsed during EXEC of POP -> no mem_we pulse; next cycle IDLE, pc=0, sp=0, mem_sel=0.
